// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding and frame constants for the frame-buffer scheduler
package fb_pkg;
  localparam int FRAME_PIXELS_DEF = 76800;
  localparam int RGB_W = 24;
  typedef enum logic [1:0] {IDLE, WRITE, PEND} state_t;
endpackage

// File: rtl/edge_det.sv
// edge_det: rising-edge detector; sys_clk/reset (async, active-low), d_i level in, rise_o one-cycle pulse
module edge_det (
  input  logic sys_clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) d_q <= 1'b0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/fb_bank_sched.sv
// fb_bank_sched: double-buffered frame writer; pixel stream in (pix_*), bank-tagged writes out (wr_*), display bank swapped on vblank, frame/error counters
module fb_bank_sched
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W = 17,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             vblank,
  output logic             wr_en,
  output logic [ADDR_W:0]  wr_addr,
  output logic [RGB_W-1:0] wr_data,
  output logic             rd_bank,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  if (64'(FRAME_PIXELS) > (64'd1 << ADDR_W)) begin : g_chk
    $fatal(1, "FRAME_PIXELS exceeds 2**ADDR_W");
  end
  state_t state_q;
  logic [ADDR_W-1:0] off_q, wr_off;
  logic [TO_W-1:0] to_q;
  logic rd_bank_q, wr_en_q, acc, rise;
  logic [15:0] frame_cnt_q;
  logic [7:0] err_cnt_q, err_d;
  logic [ADDR_W:0] wr_addr_q;
  logic [RGB_W-1:0] wr_data_q;
  edge_det u_vb (.sys_clk(sys_clk), .reset(reset), .d_i(vblank), .rise_o(rise));
  assign pix_ready = state_q != PEND;
  assign acc = pix_valid & pix_ready;
  // a start-of-frame pixel always lands at offset 0, whether it opens or restarts a frame
  assign wr_off = (state_q == IDLE || pix_sof) ? '0 : off_q;
  assign err_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_bank = rd_bank_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt = err_cnt_q;
  always_ff @(posedge sys_clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      off_q <= '0;
      to_q <= '0;
      rd_bank_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= acc & (state_q == WRITE | pix_sof);
      wr_addr_q <= {~rd_bank_q, wr_off};
      wr_data_q <= pix_data;
      case (state_q)
        IDLE:
          if (acc & pix_sof) begin
            off_q <= ADDR_W'(1);
            to_q <= '0;
            state_q <= WRITE;
          end
        WRITE:
          if (acc) begin
            to_q <= '0;
            off_q <= wr_off + 1'b1;
            if (pix_sof) err_cnt_q <= err_d;
            else if (off_q == LAST) state_q <= PEND;
          end else if (to_q == TO_LAST) begin
            err_cnt_q <= err_d;
            to_q <= '0;
            state_q <= IDLE;
          end else to_q <= to_q + 1'b1;
        PEND:
          if (rise) begin
            rd_bank_q <= ~rd_bank_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fb_bank_sched.sv
// tb_fb_bank_sched: scoreboard bench with a frame-level reference model
module tb_fb_bank_sched;
  localparam int FP = 512, AW = 17, TO = 50;
  logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0, vblank = 0;
  logic [23:0] pix_data = 0;
  logic pix_ready, wr_en, rd_bank;
  logic [AW:0] wr_addr;
  logic [23:0] wr_data;
  logic [15:0] frame_cnt;
  logic [7:0] err_cnt;
  always #5 clk = ~clk;
  fb_bank_sched #(.FRAME_PIXELS(FP), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .reset(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .vblank(vblank), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  int passed = 0, total = 0;
  typedef struct {logic [AW:0] addr; logic [23:0] data;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  // model: mode 0 = waiting for a frame, 1 = filling, 2 = frame complete awaiting vblank
  int mode = 0, pos = 0, frames = 0, errs = 0, idle_run = 0;
  bit bank = 0, vb_prev = 0, m_acc, m_rise;
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic push(input int off);
    wr_t e;
    e.addr = {~bank, AW'(off)};
    e.data = pix_data;
    exp_q.push_back(e);
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0; pos = 0; frames = 0; errs = 0; idle_run = 0; bank = 0; vb_prev = 0;
      exp_q.delete();
    end else begin
      m_acc = pix_valid && mode != 2;
      m_rise = vblank && !vb_prev;
      vb_prev = vblank;
      if (mode == 0) begin
        if (m_acc && pix_sof) begin push(0); pos = 1; mode = 1; idle_run = 0; end
      end else if (mode == 1) begin
        if (m_acc) begin
          idle_run = 0;
          if (pix_sof) begin
            errs = errs < 255 ? errs + 1 : 255;
            push(0); pos = 1;
          end else begin
            push(pos);
            if (pos == FP - 1) mode = 2;
            pos++;
          end
        end else begin
          idle_run++;
          if (idle_run == TO) begin errs = errs < 255 ? errs + 1 : 255; mode = 0; idle_run = 0; end
        end
      end else if (m_rise) begin
        bank = ~bank; frames = (frames + 1) % 65536; mode = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
      end
    end else if (exp_q.size() != 0) begin
      check("wr_missing", 0, exp_q.size());
      exp_q.delete();
    end
    check("pix_ready", pix_ready, mode != 2);
    check("rd_bank", rd_bank, bank);
    check("frame_cnt", frame_cnt, frames);
    check("err_cnt", err_cnt, errs);
  end
  task automatic cyc(input bit v, input bit s, input bit vb);
    pix_valid = v; pix_sof = s; pix_data = 24'($urandom); vblank = vb;
    @(posedge clk); #1;
  endtask
  task automatic frame(input int n, input bit vb_last);
    cyc(1, 1, 0);
    for (int i = 1; i < n; i++) cyc(1, 0, vb_last && i == n - 1);
  endtask
  task automatic vpulse();
    cyc(0, 0, 1); cyc(0, 0, 0);
  endtask
  initial begin
    bit vb;
    repeat (3) cyc(0, 0, 0);
    rst_n = 1;
    cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    frame(FP, 0);
    repeat (3) cyc(1, 0, 0);
    vpulse();
    repeat (2) cyc(0, 0, 0);
    frame(FP, 1);
    repeat (3) cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    vpulse();
    frame(101, 0);
    frame(FP, 0);
    vpulse();
    frame(11, 0);
    repeat (TO) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    frame(11, 0);
    repeat (TO - 1) cyc(0, 0, 0);
    repeat (FP - 11) cyc(1, 0, 0);
    vpulse();
    repeat (261) cyc(1, 1, 0);
    repeat (2) cyc(0, 0, 0);
    vb = 0;
    cyc(1, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) vb = ~vb;
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 399) == 0, vb);
    end
    vpulse(); vpulse();
    repeat (TO + 2) cyc(0, 0, 0);
    frame(300, 0);
    rst_n = 0;
    #1;
    check("rst_pix_ready", pix_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) cyc(0, 0, 0);
    rst_n = 1;
    frame(FP, 0);
    vpulse();
    repeat (3) cyc(0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
